// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and helpers for the Dcache dirty-bit tracker:
//                walker state encoding and a constant-foldable clog2.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  // Flush walker states
  typedef enum logic [1:0] {
    WK_IDLE  = 2'd0,
    WK_SCAN  = 2'd1,
    WK_OFFER = 2'd2,
    WK_DONE  = 2'd3
  } walk_state_t;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(33) = 6
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_dirty_walker.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_dirty_walker
//  Description : Flush walker. Steps a (set, way) pointer over the whole
//                dirty store, offers each dirty entry to the write-back unit
//                and strobes a clear when the offer is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_dirty_walker
  import dcache_pkg::*;
#(
  parameter int SET_ADDR_W = 4,
  parameter int WAYS       = 2,
  localparam int WAY_W     = clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush_req,
  input  logic                  i_entry_dirty,
  input  logic                  i_fl_ready,
  output logic [SET_ADDR_W-1:0] o_ptr_set,
  output logic [WAY_W-1:0]      o_ptr_way,
  output logic                  o_clr,
  output logic                  o_busy,
  output logic                  o_fl_valid,
  output logic                  o_done
);

  localparam logic [SET_ADDR_W-1:0] c_LAST_SET = '1;
  localparam logic [WAY_W-1:0]      c_LAST_WAY = WAY_W'(WAYS - 1);

  walk_state_t           r_state, w_state_nxt;
  logic [SET_ADDR_W-1:0] r_set, w_set_nxt;
  logic [WAY_W-1:0]      r_way, w_way_nxt;
  logic                  w_last;

  assign w_last    = (r_set == c_LAST_SET) && (r_way == c_LAST_WAY);
  assign o_ptr_set = r_set;
  assign o_ptr_way = r_way;

  // State and pointer registers; reset abandons any walk without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WK_IDLE;
      r_set   <= '0;
      r_way   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_set   <= w_set_nxt;
      r_way   <= w_way_nxt;
    end
  end

  // Next state, pointer advance (way first, then set) and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_set_nxt   = r_set;
    w_way_nxt   = r_way;
    o_clr       = 1'b0;
    o_busy      = 1'b0;
    o_fl_valid  = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      WK_IDLE: begin
        if (i_flush_req) begin
          w_state_nxt = WK_SCAN;
          w_set_nxt   = '0;
          w_way_nxt   = '0;
        end
      end
      WK_SCAN: begin
        o_busy = 1'b1;
        if (i_entry_dirty) begin
          w_state_nxt = WK_OFFER;
        end else if (w_last) begin
          w_state_nxt = WK_DONE;
        end else if (r_way == c_LAST_WAY) begin
          w_way_nxt = '0;
          w_set_nxt = r_set + SET_ADDR_W'(1);
        end else begin
          w_way_nxt = r_way + WAY_W'(1);
        end
      end
      WK_OFFER: begin
        o_busy     = 1'b1;
        o_fl_valid = 1'b1;
        if (i_fl_ready) begin
          o_clr = 1'b1;
          if (w_last) begin
            w_state_nxt = WK_DONE;
          end else begin
            w_state_nxt = WK_SCAN;
            if (r_way == c_LAST_WAY) begin
              w_way_nxt = '0;
              w_set_nxt = r_set + SET_ADDR_W'(1);
            end else begin
              w_way_nxt = r_way + WAY_W'(1);
            end
          end
        end
      end
      WK_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = WK_IDLE;
      end
      default: begin
        w_state_nxt = WK_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dcache_dirty_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_dirty_tracker
//  Description : Per-set, per-way dirty-bit store with combinational lookup,
//                a running dirty-entry count and a flush walker that hands
//                every dirty entry to the write-back unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_dirty_tracker
  import dcache_pkg::*;
#(
  parameter int SET_ADDR_W = 4,
  parameter int WAYS       = 2,
  localparam int SETS      = 2 ** SET_ADDR_W,
  localparam int WAY_W     = clog2(WAYS),
  localparam int CNT_W     = clog2(SETS * WAYS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SET_ADDR_W-1:0] i_lk_addr,
  input  logic [WAY_W-1:0]      i_lk_way,
  output logic                  o_lk_dirty,
  output logic [WAYS-1:0]       o_lk_dirty_vec,
  input  logic [SET_ADDR_W-1:0] i_upd_addr,
  input  logic [WAY_W-1:0]      i_upd_way,
  input  logic                  i_upd_set1,
  input  logic                  i_upd_set0,
  output logic [CNT_W-1:0]      o_dirty_cnt,
  input  logic                  i_flush_req,
  output logic                  o_flush_busy,
  output logic                  o_fl_valid,
  output logic [SET_ADDR_W-1:0] o_fl_set,
  output logic [WAY_W-1:0]      o_fl_way,
  input  logic                  i_fl_ready,
  output logic                  o_flush_done
);

  // Way indices are compared one bit wider so a non-power-of-two WAYS fits
  localparam logic [WAY_W:0] c_WAYS = (WAY_W + 1)'(WAYS);

  logic [WAYS-1:0]       r_dirty     [SETS];
  logic [WAYS-1:0]       w_dirty_nxt [SETS];
  logic [CNT_W-1:0]      r_cnt;
  logic [SET_ADDR_W-1:0] w_ptr_set;
  logic [WAY_W-1:0]      w_ptr_way;
  logic                  w_clr, w_entry_dirty;
  logic                  w_lk_ok, w_upd_ok, w_upd_bit, w_same;
  logic                  w_inc, w_dec_upd, w_dec_clr;

  assign w_lk_ok  = ({1'b0, i_lk_way}  < c_WAYS);
  assign w_upd_ok = ({1'b0, i_upd_way} < c_WAYS);

  assign o_lk_dirty_vec = r_dirty[i_lk_addr];
  assign o_lk_dirty     = w_lk_ok & o_lk_dirty_vec[i_lk_way];
  assign w_entry_dirty  = r_dirty[w_ptr_set][w_ptr_way];

  dcache_dirty_walker #(
    .SET_ADDR_W (SET_ADDR_W),
    .WAYS       (WAYS)
  ) u_walker (
    .clk           (clk),
    .rst           (rst),
    .i_flush_req   (i_flush_req),
    .i_entry_dirty (w_entry_dirty),
    .i_fl_ready    (i_fl_ready),
    .o_ptr_set     (w_ptr_set),
    .o_ptr_way     (w_ptr_way),
    .o_clr         (w_clr),
    .o_busy        (o_flush_busy),
    .o_fl_valid    (o_fl_valid),
    .o_done        (o_flush_done)
  );

  assign o_fl_set    = w_ptr_set;
  assign o_fl_way    = w_ptr_way;
  assign o_dirty_cnt = r_cnt;

  // Next dirty image: walker clear, then set0, then set1 so set1 wins on overlap
  always_comb begin
    w_dirty_nxt = r_dirty;
    if (w_clr) w_dirty_nxt[w_ptr_set][w_ptr_way] = 1'b0;
    if (w_upd_ok && i_upd_set0) w_dirty_nxt[i_upd_addr][i_upd_way] = 1'b0;
    if (w_upd_ok && i_upd_set1) w_dirty_nxt[i_upd_addr][i_upd_way] = 1'b1;
  end

  // Count deltas: only real 0->1 / 1->0 transitions move the counter, and a
  // walker clear on the entry being updated this cycle is already covered
  always_comb begin
    w_upd_bit = w_upd_ok & r_dirty[i_upd_addr][i_upd_way];
    w_same    = w_upd_ok && (i_upd_addr == w_ptr_set) && (i_upd_way == w_ptr_way);
    w_inc     = w_upd_ok & i_upd_set1 & ~w_upd_bit;
    w_dec_upd = w_upd_ok & ~i_upd_set1 & i_upd_set0 & w_upd_bit;
    w_dec_clr = w_clr & w_entry_dirty & ~(w_same & (i_upd_set1 | i_upd_set0));
  end

  // Dirty storage and running count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) r_dirty[s] <= '0;
      r_cnt <= '0;
    end else begin
      r_dirty <= w_dirty_nxt;
      r_cnt   <= r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec_upd) - CNT_W'(w_dec_clr);
    end
  end

endmodule
`default_nettype wire
